// File: rtl/mpc_vec_ram_1rw1r.sv
// Vector buffer: port 0 read/write, port 1 read-only, with a hardware clear sequencer.
// Optional macro MPC_RAM_OUTREG_EN adds an output register stage (read latency 2).
module mpc_vec_ram_1rw1r #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 5,
    parameter int AddressRange = 24,
    parameter int WriteFirst   = 0,
    parameter int ClearOnReset = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [AddressWidth-1:0] address0,
    input  logic                    ce0,
    input  logic                    we0,
    input  logic [DataWidth-1:0]    d0,
    output logic [DataWidth-1:0]    q0,
    input  logic [AddressWidth-1:0] address1,
    input  logic                    ce1,
    output logic [DataWidth-1:0]    q1,
    input  logic                    clr_start,
    output logic                    clr_busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [AddressWidth:0]   LP_RANGE     = (AddressWidth+1)'(AddressRange);
    localparam logic [AddressWidth-1:0] LP_LAST      = AddressWidth'(AddressRange - 1);
    localparam bit                      LP_WF        = (WriteFirst != 0);
    localparam bit                      LP_CLR_RST   = (ClearOnReset != 0);
    localparam state_t                  LP_RST_STATE = LP_CLR_RST ? ST_CLEAR : ST_IDLE;

    // Sized to the full address space so any address indexes cleanly; entries
    // at or above AddressRange are never written and their reads are masked to 0.
    logic [DataWidth-1:0]    r_mem [2**AddressWidth];

    state_t                  r_state;
    logic                    r_busy;
    logic [AddressWidth-1:0] r_cnt;
    logic [DataWidth-1:0]    r_q0;
    logic [DataWidth-1:0]    r_q1;

    logic                    w_idle;
    logic                    w_in0;
    logic                    w_in1;
    logic                    w_wr0;
    logic                    w_coll;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_in0    = ({1'b0, address0} < LP_RANGE);
    assign w_in1    = ({1'b0, address1} < LP_RANGE);
    assign w_wr0    = reset & w_idle & ce0 & we0 & w_in0;
    assign w_coll   = w_wr0 & ce1 & (address1 == address0);
    assign clr_busy = r_busy;

    // Clear sequencer: sweeps ram[0..AddressRange-1] once, one word per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= LP_RST_STATE;
            r_busy  <= LP_CLR_RST;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr_start) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == LP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Array write port: the clear sweep owns the array while it runs.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr0) begin
            r_mem[address0] <= d0;
        end
    end

    // Read registers: hold while disabled or busy; out-of-range reads return 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else begin
            if (w_idle && ce0) begin
                if (!w_in0) begin
                    r_q0 <= '0;
                end else if (we0 && LP_WF) begin
                    r_q0 <= d0;
                end else begin
                    r_q0 <= r_mem[address0];
                end
            end
            if (w_idle && ce1) begin
                if (!w_in1) begin
                    r_q1 <= '0;
                end else if (w_coll && LP_WF) begin
                    r_q1 <= d0;
                end else begin
                    r_q1 <= r_mem[address1];
                end
            end
        end
    end

`ifdef MPC_RAM_OUTREG_EN
    logic [DataWidth-1:0] r_q0_o;
    logic [DataWidth-1:0] r_q1_o;

    // Output stage advances every cycle, clear sweep included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q0_o <= '0;
            r_q1_o <= '0;
        end else begin
            r_q0_o <= r_q0;
            r_q1_o <= r_q1;
        end
    end

    assign q0 = r_q0_o;
    assign q1 = r_q1_o;
`else
    assign q0 = r_q0;
    assign q1 = r_q1;
`endif

endmodule

// File: tb/tb_mpc_vec_ram_1rw1r.sv
// Scoreboard bench for mpc_vec_ram_1rw1r: stimulus queues expected reads,
// a negedge monitor pops and compares them when their read latency elapses.
module tb_mpc_vec_ram_1rw1r;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int AR = 24;
    localparam int WF = 0;
`ifdef MPC_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address0;
    logic          ce0;
    logic          we0;
    logic [DW-1:0] d0;
    logic [DW-1:0] q0;
    logic [AW-1:0] address1;
    logic          ce1;
    logic [DW-1:0] q1;
    logic          clr_start;
    logic          clr_busy;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    mpc_vec_ram_1rw1r #(
        .DataWidth   (DW),
        .AddressWidth(AW),
        .AddressRange(AR),
        .WriteFirst  (WF),
        .ClearOnReset(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address0 (address0),
        .ce0      (ce0),
        .we0      (we0),
        .d0       (d0),
        .q0       (q0),
        .address1 (address1),
        .ce1      (ce1),
        .q1       (q1),
        .clr_start(clr_start),
        .clr_busy (clr_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation whose read latency has elapsed.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = e.port ? q1 : q0;
            total++;
            if (e.due != cyc || act !== e.exp) begin
                bad++;
                $display("FAIL %s port%0d: got %h expected %h (due %0d now %0d)",
                         e.name, e.port, act, e.exp, e.due, cyc);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle of port activity; called at a negedge, returns at the next one.
    task automatic io(input logic c0, input logic w0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] dd, input logic c1, input logic [AW-1:0] a1,
                      input bit k0, input logic [31:0] e0,
                      input bit k1, input logic [31:0] e1, input string nm);
        exp_t e;
        ce0 = c0; we0 = w0; address0 = a0; d0 = dd; ce1 = c1; address1 = a1;
        if (k0) begin
            e.due = cyc + LAT; e.port = 1'b0; e.exp = e0; e.name = nm;
            sb.push_back(e);
        end
        if (k1) begin
            e.due = cyc + LAT; e.port = 1'b1; e.exp = e1; e.name = nm;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        ce0 = 1'b0; we0 = 1'b0; ce1 = 1'b0; clr_start = 1'b0;
    endtask

    // Count negedge samples with clr_busy high; optionally pulse clr_start mid-sweep.
    task automatic count_busy(input int exp_n, input int pulse_at, input string nm);
        int n;
        n = 0;
        while (clr_busy && n < 200) begin
            clr_start = (n == pulse_at);
            @(negedge clk);
            n++;
        end
        idle();
        check(nm, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        address0 = '0; address1 = '0; d0 = '0;
        idle();
        repeat (3) @(negedge clk);
        check("rst_q0", q0, 32'h0);
        check("rst_q1", q1, 32'h0);
        check("rst_busy", 32'(clr_busy), 32'h1);

        // Test 1: automatic clear after reset, then everything reads 0.
        reset = 1'b1;
        count_busy(AR, -1, "busy_after_reset");
        for (int i = 0; i < AR; i++)
            io(1'b1, 1'b0, AW'(i), '0, 1'b1, AW'(AR - 1 - i), 1'b1, 32'h0, 1'b1, 32'h0, "clear_rd");

        // Test 2: write then read back on port 1.
        io(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1, WF ? 32'hDEAD_BEEF : 32'h0, 1'b0, 32'h0, "wr5_q0");
        io(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd5, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, "rd5_p1");
        io(1'b1, 1'b1, 5'd6, 32'h6666_6666, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, "wr6");
        io(1'b1, 1'b1, 5'd14, 32'h1414_1414, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, "wr14");

        // Test 3: read-during-write collision on both ports.
        io(1'b1, 1'b1, 5'd7, 32'h1111_1111, 1'b0, 5'd0, 1'b1, WF ? 32'h1111_1111 : 32'h0, 1'b0, 32'h0, "wr7a");
        io(1'b1, 1'b1, 5'd7, 32'h2222_2222, 1'b1, 5'd7, 1'b1, WF ? 32'h2222_2222 : 32'h1111_1111,
           1'b1, WF ? 32'h2222_2222 : 32'h1111_1111, "collide7");
        io(1'b1, 1'b0, 5'd7, '0, 1'b1, 5'd7, 1'b1, 32'h2222_2222, 1'b1, 32'h2222_2222, "rd7_after");

        // Test 4: out-of-range write is dropped, out-of-range read gives 0.
        io(1'b1, 1'b0, 5'd6, '0, 1'b1, 5'd14, 1'b1, 32'h6666_6666, 1'b1, 32'h1414_1414, "rd6_14_pre");
        io(1'b1, 1'b1, 5'd30, 32'h0000_ABCD, 1'b1, 5'd30, 1'b1, 32'h0, 1'b1, 32'h0, "oor30");
        io(1'b1, 1'b0, 5'd6, '0, 1'b1, 5'd14, 1'b1, 32'h6666_6666, 1'b1, 32'h1414_1414, "rd6_14_post");

        // Test 6a: disabled ports hold their output while the address moves.
        io(1'b1, 1'b0, 5'd5, '0, 1'b1, 5'd7, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h2222_2222, "hold_setup");
        io(1'b0, 1'b0, 5'd7, '0, 1'b0, 5'd3, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h2222_2222, "hold1");
        io(1'b0, 1'b0, 5'd3, '0, 1'b0, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h2222_2222, "hold2");

        // Test 5: fill, clear, reset mid-sweep, writes during busy dropped.
        for (int i = 0; i < AR; i++)
            io(1'b1, 1'b1, AW'(i), 32'h1000 + 32'(i), 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, "fill");
        io(1'b1, 1'b0, 5'd5, '0, 1'b1, 5'd4, 1'b1, 32'h1005, 1'b1, 32'h1004, "fill_rd");
        idle();
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        ce0 = 1'b1; we0 = 1'b0; address0 = 5'd1; ce1 = 1'b1; address1 = 5'd2;
        for (int i = 0; i < 10; i++) begin
            check("busy_clr", 32'(clr_busy), 32'h1);
            check("busy_hold_q0", q0, 32'h1005);
            check("busy_hold_q1", q1, 32'h1004);
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(clr_busy), 32'h1);
        check("midrst_q0", q0, 32'h0);
        ce0 = 1'b1; we0 = 1'b1; address0 = 5'd0; d0 = 32'h5555_5555;
        reset = 1'b1;
        // Test 6b: clr_start pulsed mid-sweep must not extend it.
        count_busy(AR, 5, "busy_restart");
        for (int i = 0; i < AR; i++)
            io(1'b1, 1'b0, AW'(i), '0, 1'b1, AW'(AR - 1 - i), 1'b1, 32'h0, 1'b1, 32'h0, "final_rd");

        idle();
        repeat (LAT + 2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpc_vec_ram_1rw1r.md
Name: mpc_vec_ram_1rw1r

Overview:
Parametrised successor to the single-port HLS-generated vector buffers in the MPC controller. Port 0 is read/write and port 1 is read-only, so the solver can stream a vector out while updating it. Both ports share one clock. The block adds a selectable read-during-write mode, address range checking, and a hardware clear sequencer that zeroes the array after reset or on request. It sits between the HLS datapath and the iterate, gradient and bound vectors.

Parameters:
DataWidth, 32, word width in bits
AddressWidth, 5, address bus width
AddressRange, 24, number of valid words (must be <= 2**AddressWidth)
WriteFirst, 0, 0 = read-first (old data on collision), 1 = write-first (new data on collision)
ClearOnReset, 1, 1 = clear sequencer starts automatically when reset is released

Ports:
clk  input  1  clock; all logic is rising-edge
reset  input  1  asynchronous, active-low reset
address0  input  AddressWidth  port 0 address
ce0  input  1  port 0 enable
we0  input  1  port 0 write enable; qualified by ce0
d0  input  DataWidth  port 0 write data
q0  output  DataWidth  port 0 read data
address1  input  AddressWidth  port 1 address
ce1  input  1  port 1 enable
q1  output  DataWidth  port 1 read data
clr_start  input  1  one-cycle pulse that requests a full clear
clr_busy  output  1  high while the clear sequencer runs; user accesses are ignored

Behaviour:
- Reset (reset=0): q0=0, q1=0, clear counter=0.
  - ClearOnReset=1: FSM=CLEAR, clr_busy=1.
  - ClearOnReset=0: FSM=IDLE, clr_busy=0.
  - Array contents are not reset asynchronously.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on clr_start=1. Counter loads 0 and clr_busy rises on the next edge.
  - In CLEAR, each cycle writes 0 to ram[counter] and increments the counter.
  - After the cycle that writes AddressRange-1, the next edge returns to IDLE and clr_busy=0. A clear therefore takes exactly AddressRange cycles.
  - clr_start is ignored while in CLEAR.
  - Reset asserted mid-clear aborts the sweep and reapplies the reset rules above, so the sweep restarts from 0 when ClearOnReset=1.
- While clr_busy=1: ce0, we0 and ce1 are ignored; q0 and q1 hold their last value.
- Read latency is 1 cycle. ce low holds q.
- Port 0 write (IDLE, ce0=1, we0=1, address0<AddressRange): ram[address0] <= d0 at the edge.
  - q0 returns old data when WriteFirst=0, or d0 when WriteFirst=1.
- Cross-port collision: ce1=1 with address1==address0 while port 0 writes.
  - q1 returns old data when WriteFirst=0, or d0 when WriteFirst=1.
- Out-of-range address (>=AddressRange):
  - A write is dropped and the array is unchanged.
  - The read value for that port is 0 on the next cycle.
- Simultaneous reads by both ports of the same address are legal and return identical data.
- All data is unsigned and passed through unchanged; there is no arithmetic on the data path.

Optional Feature:
MPC_RAM_OUTREG_EN:
- Defined: one extra output register stage on q0 and q1, giving read latency 2. The stage advances every cycle, including while clr_busy=1. Its reset value is 0. Collision and out-of-range results are delayed by the same one cycle.
- Undefined: read latency is 1, exactly as described in Behaviour.

Test Plan:
1. Reset release, ClearOnReset=1, AddressRange=24 -> clr_busy high for exactly 24 cycles. Then read all 24 addresses on both ports -> all 0.
2. Write 0xDEADBEEF to address 5 via port 0, then read address 5 on port 1 the next cycle -> q1=0xDEADBEEF after 1 cycle (2 cycles with MPC_RAM_OUTREG_EN).
3. ram[7]=0x11111111. In the same cycle, port 0 writes 0x22222222 to address 7 and port 1 reads address 7.
   - WriteFirst=0 -> q0=q1=0x11111111.
   - WriteFirst=1 -> q0=q1=0x22222222.
   - In both cases a later read returns 0x22222222.
4. Write 0xABCD to address 30 (out of range) -> the array is unchanged. A read of address 30 -> q=0. A read of address 6 is unaffected.
5. Pulse clr_start after filling the array with nonzero data. Assert reset for 1 cycle at clear counter=10 -> the sweep restarts from 0 and runs a full 24 cycles. Port 0 writes issued while busy are dropped, and the final contents are all 0.
6. ce0=0 with the address changing -> q0 holds its previous value. clr_start while busy -> no extension of clr_busy.
